// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time against a word array, with byte enables.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept cycle.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
module dm_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("dm_responder: WAIT_CYCLES must be in 0..15");
        end
        if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr
            $error("dm_responder: ADDR_W must be in 1..29");
        end
    endgenerate

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef struct packed {
        logic              we;
        logic              oob;
        logic [ADDR_W-1:0] idx;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        cap;
    req_t        req_in;
    req_t        acc;
    logic        commit;
    logic        rsp_done;
    logic        capture;
    logic [31:0] rd_word;
    logic        unused_addr;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    assign req_in.we    = req_we;
    assign req_in.oob   = |req_addr[31:ADDR_W+2];
    assign req_in.idx   = req_addr[ADDR_W+1:2];
    assign req_in.be    = req_be;
    assign req_in.wdata = req_wdata;
    assign unused_addr  = ^req_addr[1:0];

    // With zero wait states the access commits on the accept edge straight from the inputs.
    assign acc       = (state == ST_IDLE) ? req_in : cap;
    assign rd_word   = mem[acc.idx];
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        rsp_done  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap       <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                cap <= req_in;
            end
            if (commit) begin
                rsp_rdata <= (acc.we || acc.oob) ? 32'd0 : rd_word;
                rsp_err   <= acc.oob;
            end else if (rsp_done) begin
                rsp_rdata <= 32'd0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Array has no reset; the rst gate keeps a pending store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc.we && !acc.oob) begin
            for (int i = 0; i < 4; i++) begin
                if (acc.be[i]) begin
                    mem[acc.idx][8*i +: 8] <= acc.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
